if_id_queue: RTL and testbench

Parametrised, decoupled IF→ID pipeline buffer: a DEPTH-entry first-word-fall-through queue of {pc, instruction} pairs with valid/ready handshakes on both sides. Replaces the single-entry IF/ID latch so fetch can run ahead of a stalled decoder. Presents a NOP bubble to ID whenever the queue is empty. Honours a global ready gate and a stage-clear (branch flush).

---
 rtl/if_id_queue.sv | 75 +++++++
 tb/tb_if_id_queue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Decoupled IF->ID buffer: DEPTH-entry first-word-fall-through queue of {pc, instruction}.
// Presents a NOP bubble to ID when empty; clear flushes all entries, rdy_in low freezes state.
module if_id_queue #(
    parameter int          XLEN    = 32,
    parameter int          DEPTH   = 4,
    parameter logic [31:0] NOP_PC  = 32'h0,
    parameter logic [31:0] NOP_INS = 32'h00000013
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       clear,
    input  logic                       if_valid,
    input  logic [XLEN-1:0]            if_pc,
    input  logic [XLEN-1:0]            if_ins,
    output logic                       if_ready,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_ins,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] ins_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    // if_ready depends only on registered occupancy, never on id_ready
    assign if_ready = rdy_in && !full && !clear;
    assign id_valid = !empty;
    assign id_pc    = empty ? NOP_PC[XLEN-1:0]  : pc_mem[rd_ptr];
    assign id_ins   = empty ? NOP_INS[XLEN-1:0] : ins_mem[rd_ptr];

    assign push = if_valid && if_ready;
    assign pop  = id_valid && id_ready && rdy_in && !clear;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Storage is not reset; stale entries are masked by the empty bubble
    always_ff @(posedge clk_in) begin
        if (push) begin
            pc_mem[wr_ptr]  <= if_pc;
            ins_mem[wr_ptr] <= if_ins;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: vector table for fill/drain/flush/freeze plus
// hand-written reset sequences.
module tb_if_id_queue;

    localparam logic [31:0] NOP_PC  = 32'h0;
    localparam logic [31:0] NOP_INS = 32'h00000013;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        if_ready;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_ins;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    if_id_queue #(.XLEN(32), .DEPTH(4), .NOP_PC(NOP_PC), .NOP_INS(NOP_INS)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear    (clear),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_ins   (if_ins),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_ins   (id_ins),
        .count    (count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        clr;
        logic        vld;
        logic [31:0] pc;
        logic        idr;
        logic [2:0]  e_cnt;
        logic        e_val;
        logic [31:0] e_pc;
        logic        e_ifr;
    } vec_t;

    vec_t vecs [29];

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0033};
    endfunction

    function automatic vec_t mk(input logic rdy, input logic clr, input logic vld,
                                input logic [31:0] pc, input logic idr,
                                input logic [2:0] e_cnt, input logic e_val,
                                input logic [31:0] e_pc, input logic e_ifr);
        vec_t v;
        v.rdy = rdy; v.clr = clr; v.vld = vld; v.pc = pc; v.idr = idr;
        v.e_cnt = e_cnt; v.e_val = e_val; v.e_pc = e_pc; v.e_ifr = e_ifr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_cnt, input logic e_val,
                           input logic [31:0] e_pc, input logic e_ifr);
        chk({tag, " count"},    32'(count),    32'(e_cnt));
        chk({tag, " id_valid"}, 32'(id_valid), 32'(e_val));
        chk({tag, " id_pc"},    id_pc,         e_val ? e_pc : NOP_PC);
        chk({tag, " id_ins"},   id_ins,        e_val ? ins_of(e_pc) : NOP_INS);
        chk({tag, " if_ready"}, 32'(if_ready), 32'(e_ifr));
    endtask

    task automatic drive(input logic rdy, input logic clr, input logic vld,
                         input logic [31:0] pc, input logic idr);
        rdy_in   = rdy;
        clear    = clr;
        if_valid = vld;
        if_pc    = pc;
        if_ins   = ins_of(pc);
        id_ready = idr;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // fill to full, then a fifth offer that must be refused
        vecs[0]  = mk(1, 0, 1, 32'h100, 0, 3'd1, 1, 32'h100, 1);
        vecs[1]  = mk(1, 0, 1, 32'h104, 0, 3'd2, 1, 32'h100, 1);
        vecs[2]  = mk(1, 0, 1, 32'h108, 0, 3'd3, 1, 32'h100, 1);
        vecs[3]  = mk(1, 0, 1, 32'h10C, 0, 3'd4, 1, 32'h100, 0);
        vecs[4]  = mk(1, 0, 1, 32'h110, 0, 3'd4, 1, 32'h100, 0);
        // drain with concurrent pushes; pointers wrap
        vecs[5]  = mk(1, 0, 1, 32'h110, 1, 3'd3, 1, 32'h104, 1);
        vecs[6]  = mk(1, 0, 1, 32'h110, 1, 3'd3, 1, 32'h108, 1);
        vecs[7]  = mk(1, 0, 1, 32'h114, 1, 3'd3, 1, 32'h10C, 1);
        vecs[8]  = mk(1, 0, 1, 32'h118, 1, 3'd3, 1, 32'h110, 1);
        vecs[9]  = mk(1, 0, 1, 32'h11C, 1, 3'd3, 1, 32'h114, 1);
        vecs[10] = mk(1, 0, 0, 32'h0,   1, 3'd2, 1, 32'h118, 1);
        vecs[11] = mk(1, 0, 0, 32'h0,   1, 3'd1, 1, 32'h11C, 1);
        vecs[12] = mk(1, 0, 0, 32'h0,   1, 3'd0, 0, 32'h0,   1);
        vecs[13] = mk(1, 0, 0, 32'h0,   1, 3'd0, 0, 32'h0,   1);
        // push+pop at count 1
        vecs[14] = mk(1, 0, 1, 32'h200, 1, 3'd1, 1, 32'h200, 1);
        vecs[15] = mk(1, 0, 1, 32'h204, 1, 3'd1, 1, 32'h204, 1);
        vecs[16] = mk(1, 0, 0, 32'h0,   0, 3'd1, 1, 32'h204, 1);
        // flush at count 3 with simultaneous push and pop
        vecs[17] = mk(1, 0, 1, 32'h208, 0, 3'd2, 1, 32'h204, 1);
        vecs[18] = mk(1, 0, 1, 32'h20C, 0, 3'd3, 1, 32'h204, 1);
        vecs[19] = mk(1, 1, 1, 32'h300, 1, 3'd0, 0, 32'h0,   0);
        vecs[20] = mk(1, 0, 1, 32'h304, 0, 3'd1, 1, 32'h304, 1);
        vecs[21] = mk(1, 0, 1, 32'h308, 0, 3'd2, 1, 32'h304, 1);
        // rdy_in freeze, then clear while frozen
        vecs[22] = mk(0, 0, 1, 32'h30C, 1, 3'd2, 1, 32'h304, 0);
        vecs[23] = mk(0, 0, 1, 32'h30C, 1, 3'd2, 1, 32'h304, 0);
        vecs[24] = mk(0, 0, 1, 32'h30C, 1, 3'd2, 1, 32'h304, 0);
        vecs[25] = mk(0, 0, 1, 32'h30C, 1, 3'd2, 1, 32'h304, 0);
        vecs[26] = mk(0, 0, 1, 32'h30C, 1, 3'd2, 1, 32'h304, 0);
        vecs[27] = mk(0, 1, 0, 32'h0,   0, 3'd0, 0, 32'h0,   0);
        vecs[28] = mk(1, 0, 0, 32'h0,   0, 3'd0, 0, 32'h0,   1);

        rst_in = 1'b0;
        drive(1, 0, 0, 32'h0, 0);
        #12;
        chk_out("reset", 3'd0, 1'b0, 32'h0, 1'b1);
        rst_in = 1'b1;

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].rdy, vecs[i].clr, vecs[i].vld, vecs[i].pc, vecs[i].idr);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_val,
                    vecs[i].e_pc, vecs[i].e_ifr);
        end

        // asynchronous reset mid-operation drops entries without a clock edge
        drive(1, 0, 1, 32'h500, 0);
        step();
        drive(1, 0, 1, 32'h504, 0);
        step();
        chk_out("pre_rst", 3'd2, 1'b1, 32'h500, 1'b1);
        drive(1, 0, 0, 32'h0, 0);
        #2 rst_in = 1'b0;
        #1;
        chk_out("async_rst", 3'd0, 1'b0, 32'h0, 1'b1);
        #2 rst_in = 1'b1;
        drive(1, 0, 1, 32'h400, 0);
        step();
        chk_out("post_rst", 3'd1, 1'b1, 32'h400, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
